// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: keeps one instruction-memory fetch in flight, buffers the
// returned word for decode, selects the next PC source and flags memory timeouts.

`ifndef INSTR_MEM_WIDTH
`define INSTR_MEM_WIDTH 32
`endif

module fetch_ctrl #(
    parameter int ADDR_W  = `INSTR_MEM_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_en,
    output logic [2:0]        pc_src,
    input  logic              redir_valid,
    input  logic [2:0]        redir_src,
    input  logic              stall,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              instr_valid,
    output logic [31:0]       instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              fetch_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [2:0]      SRC_SEQ = 3'b000;

    state_t            state, state_next;
    logic              idle_done;
    logic              drop, drop_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              redir_ok;
    logic              load_pc;
    logic              load_instr;
    logic              clear_valid;

    // Only the defined redirect sources (beq, bne, tar_addr, alu_res) count.
    assign redir_ok      = redir_valid && (redir_src inside {[3'b001:3'b100]});
    assign imem_req_addr = pc_in;
    assign fetch_err     = (state == ERR);

    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next     = state;
        drop_next      = drop;
        cnt_next       = cnt;
        pc_en          = 1'b0;
        pc_src         = SRC_SEQ;
        imem_req_valid = 1'b0;
        load_pc        = 1'b0;
        load_instr     = 1'b0;
        clear_valid    = 1'b0;

        case (state)
            IDLE: begin
                if (idle_done) state_next = REQ;
            end
            REQ: begin
                if (redir_ok) begin
                    pc_en  = 1'b1;
                    pc_src = redir_src;
                end else begin
                    imem_req_valid = 1'b1;
                    if (imem_req_ready) begin
                        load_pc    = 1'b1;
                        cnt_next   = '0;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt != CNT_MAX) cnt_next = cnt + CNT_W'(1);
                if (redir_ok) begin
                    pc_en  = 1'b1;
                    pc_src = redir_src;
                    // A response in the redirect cycle belongs to the old path.
                    if (imem_rsp_valid) begin
                        drop_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        drop_next  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop) begin
                        drop_next  = 1'b0;
                        state_next = REQ;
                    end else begin
                        load_instr = 1'b1;
                        state_next = HOLD;
                    end
                end else if (cnt_next >= CNT_MAX) begin
                    state_next = ERR;
                end
            end
            HOLD: begin
                if (redir_ok) begin
                    pc_en       = 1'b1;
                    pc_src      = redir_src;
                    clear_valid = 1'b1;
                    state_next  = REQ;
                end else if (instr_valid && instr_ready && !stall) begin
                    pc_en       = 1'b1;
                    clear_valid = 1'b1;
                    state_next  = REQ;
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idle_done <= 1'b0;
            drop      <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            idle_done <= 1'b1;
            drop      <= drop_next;
            cnt       <= cnt_next;
        end
    end

    // Decode-facing buffer; data and PC are cleared on reset so decode never sees X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_pc    <= '0;
        end else begin
            if (load_pc) instr_pc <= pc_in;
            if (load_instr) begin
                instr_data  <= imem_rsp_data;
                instr_valid <= 1'b1;
            end else if (clear_valid) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: PC register and instruction-memory models,
// a scoreboard of fetched words, a table of HOLD-state PC-select vectors and corner sequences.

module tb_fetch_ctrl;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    localparam logic [31:0] PC_RESET = 32'h0000_1000;
    localparam logic [31:0] BEQ_TGT  = 32'h0000_4000;
    localparam logic [31:0] BNE_TGT  = 32'h0000_5000;
    localparam logic [31:0] TAR_TGT  = 32'h0000_2000;
    localparam logic [31:0] ALU_TGT  = 32'h0000_3000;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] pc_in;
    logic              pc_en;
    logic [2:0]        pc_src;
    logic              redir_valid;
    logic [2:0]        redir_src;
    logic              stall;
    logic              imem_req_valid;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              instr_valid;
    logic [31:0]       instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              fetch_err;

    fetch_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_en          (pc_en),
        .pc_src         (pc_src),
        .redir_valid    (redir_valid),
        .redir_src      (redir_src),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[15:0] ^ 16'hA5C3, a[15:0]};
    endfunction

    // PC register living outside the DUT.
    always @(posedge clk or negedge rst) begin
        if (!rst) pc_in <= PC_RESET;
        else if (pc_en) begin
            case (pc_src)
                3'b000:  pc_in <= pc_in + 32'd4;
                3'b001:  pc_in <= BEQ_TGT;
                3'b010:  pc_in <= BNE_TGT;
                3'b011:  pc_in <= TAR_TGT;
                3'b100:  pc_in <= ALU_TGT;
                default: pc_in <= 32'hDEAD_0000;
            endcase
        end
    end

    // Instruction memory: responds mem_lat cycles after acceptance (0 = never).
    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       data;
    } sb_ent_t;

    sb_ent_t           sb[$];
    int                mem_lat;
    logic              drop_armed;
    logic              pend;
    logic [ADDR_W-1:0] pend_addr;
    int                wait_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
            pend           <= 1'b0;
            pend_addr      <= '0;
            wait_cnt       <= 0;
        end else begin
            imem_rsp_valid <= 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                if (mem_lat == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_word(imem_req_addr);
                    if (!drop_armed) sb.push_back('{imem_req_addr, mem_word(imem_req_addr)});
                end else if (mem_lat > 1) begin
                    pend      <= 1'b1;
                    pend_addr <= imem_req_addr;
                    wait_cnt  <= mem_lat - 1;
                end
            end else if (pend) begin
                if (wait_cnt == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_word(pend_addr);
                    pend           <= 1'b0;
                    if (!drop_armed) sb.push_back('{pend_addr, mem_word(pend_addr)});
                end else begin
                    wait_cnt <= wait_cnt - 1;
                end
            end
        end
    end

    // Scoreboard: each new instr_valid must match the oldest delivered response.
    logic iv_q = 1'b0;

    task automatic sb_compare();
        sb_ent_t e;
        if (sb.size() == 0) begin
            check("sb_unexpected_valid", instr_valid, 1'b0);
        end else begin
            e = sb.pop_front();
            check("sb_instr_pc", instr_pc, e.pc);
            check("sb_instr_data", instr_data, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (rst && instr_valid && !iv_q) sb_compare();
        iv_q <= instr_valid;
    end

    task automatic wait_req(input logic [ADDR_W-1:0] exp_addr, input string name);
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_req_valid"}, imem_req_valid, 1'b1);
        check({name, "_req_addr"}, imem_req_addr, exp_addr);
    endtask

    task automatic wait_valid(input logic [ADDR_W-1:0] exp_pc, input string name);
        int n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_instr_valid"}, instr_valid, 1'b1);
        check({name, "_instr_pc"}, instr_pc, exp_pc);
    endtask

    // HOLD-state PC-select vectors, applied and removed within one cycle.
    typedef struct {
        logic       rv;
        logic [2:0] rs;
        logic       rdy;
        logic       stl;
        logic       exp_en;
        logic [2:0] exp_src;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int          nreq;
        logic [31:0] held;

        vecs[0]  = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000};
        vecs[1]  = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 3'b000};
        vecs[2]  = '{1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 3'b000};
        vecs[3]  = '{1'b1, 3'b011, 1'b0, 1'b0, 1'b1, 3'b011};
        vecs[4]  = '{1'b1, 3'b100, 1'b1, 1'b0, 1'b1, 3'b100};
        vecs[5]  = '{1'b1, 3'b101, 1'b1, 1'b0, 1'b1, 3'b000};
        vecs[6]  = '{1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 3'b000};
        vecs[7]  = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000};
        vecs[8]  = '{1'b1, 3'b001, 1'b1, 1'b1, 1'b1, 3'b001};
        vecs[9]  = '{1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 3'b000};
        vecs[10] = '{1'b1, 3'b010, 1'b0, 1'b1, 1'b1, 3'b010};

        rst            = 1'b0;
        redir_valid    = 1'b0;
        redir_src      = 3'b000;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        mem_lat        = 1;
        drop_armed     = 1'b0;

        // Reset values.
        #12;
        check("rst_pc_en", pc_en, 1'b0);
        check("rst_pc_src", pc_src, 3'b000);
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_instr_data", instr_data, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_fetch_err", fetch_err, 1'b0);

        // First fetch: request in the second cycle, instr_valid two cycles after acceptance.
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("idle_req_valid", imem_req_valid, 1'b0);
        tick();
        check("first_req_valid", imem_req_valid, 1'b1);
        check("first_req_addr", imem_req_addr, PC_RESET);
        tick();
        check("wait_instr_valid", instr_valid, 1'b0);
        tick();
        check("hold_instr_valid", instr_valid, 1'b1);
        check("hold_instr_pc", instr_pc, PC_RESET);
        held = instr_data;

        for (int i = 0; i < 11; i++) begin
            redir_valid = vecs[i].rv;
            redir_src   = vecs[i].rs;
            instr_ready = vecs[i].rdy;
            stall       = vecs[i].stl;
            #1;
            check($sformatf("vec%0d_pc_en", i), pc_en, vecs[i].exp_en);
            check($sformatf("vec%0d_pc_src", i), pc_src, vecs[i].exp_src);
            redir_valid = 1'b0;
            redir_src   = 3'b000;
            instr_ready = 1'b0;
            stall       = 1'b0;
            #1;
        end

        // Back-pressure: instr_ready low, then stall high, then release.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_pc_en", pc_en, 1'b0);
            check("bp_instr_data", {instr_valid, instr_data}, {1'b1, held});
        end
        instr_ready = 1'b1;
        stall       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_pc_en", pc_en, 1'b0);
            check("stall_instr_data", {instr_valid, instr_data}, {1'b1, held});
            tick();
        end
        stall = 1'b0;
        #1;
        check("adv_pc_en", pc_en, 1'b1);
        check("adv_pc_src", pc_src, 3'b000);
        tick();
        check("adv_instr_valid", instr_valid, 1'b0);
        check("next_req_valid", imem_req_valid, 1'b1);
        check("next_req_addr", imem_req_addr, PC_RESET + 32'd4);

        // Steady state: one request every 3 cycles.
        nreq = 0;
        for (int i = 0; i < 9; i++) begin
            if (imem_req_valid) nreq++;
            tick();
        end
        check("cadence_requests", nreq, 3);
        instr_ready = 1'b0;

        // Redirect in HOLD together with instr_ready: redirect source wins.
        wait_valid(PC_RESET + 32'h10, "h100");
        redir_valid = 1'b1;
        redir_src   = 3'b100;
        instr_ready = 1'b1;
        #1;
        check("h100_pc_en", pc_en, 1'b1);
        check("h100_pc_src", pc_src, 3'b100);
        tick();
        redir_valid = 1'b0;
        instr_ready = 1'b0;
        #1;
        check("h100_instr_valid", instr_valid, 1'b0);
        check("h100_req_addr", {imem_req_valid, imem_req_addr}, {1'b1, ALU_TGT});

        // Invalid redirect source in HOLD is ignored.
        wait_valid(ALU_TGT, "h101");
        redir_valid = 1'b1;
        redir_src   = 3'b101;
        #1;
        check("h101_pc_en", pc_en, 1'b0);
        tick();
        redir_valid = 1'b0;
        #1;
        check("h101_instr_valid", instr_valid, 1'b1);
        instr_ready = 1'b1;
        #1;
        check("h101_adv_pc_en", pc_en, 1'b1);
        tick();
        instr_ready = 1'b0;
        #1;
        check("h101_next_addr", {imem_req_valid, imem_req_addr}, {1'b1, ALU_TGT + 32'd4});

        // Redirect in REQ suppresses the request.
        redir_valid = 1'b1;
        redir_src   = 3'b001;
        #1;
        check("req_redir_req_valid", imem_req_valid, 1'b0);
        check("req_redir_pc_en", {pc_en, pc_src}, {1'b1, 3'b001});
        tick();
        redir_valid = 1'b0;
        #1;
        check("req_redir_addr", {imem_req_valid, imem_req_addr}, {1'b1, BEQ_TGT});

        // Redirect in WAIT, response two cycles later is dropped.
        wait_valid(BEQ_TGT, "w011");
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        mem_lat     = 3;
        drop_armed  = 1'b1;
        #1;
        check("w011_req_addr", {imem_req_valid, imem_req_addr}, {1'b1, BEQ_TGT + 32'd4});
        tick();
        redir_valid = 1'b1;
        redir_src   = 3'b011;
        #1;
        check("w011_pc_en", {pc_en, pc_src}, {1'b1, 3'b011});
        tick();
        redir_valid = 1'b0;
        #1;
        check("w011_w2_instr_valid", instr_valid, 1'b0);
        tick();
        check("w011_w3_instr_valid", instr_valid, 1'b0);
        drop_armed = 1'b0;
        mem_lat    = 1;
        tick();
        check("w011_instr_valid", instr_valid, 1'b0);
        check("w011_new_req", {imem_req_valid, imem_req_addr}, {1'b1, TAR_TGT});

        // Redirect in WAIT with the response in the same cycle.
        wait_valid(TAR_TGT, "w010");
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        drop_armed  = 1'b1;
        #1;
        check("w010_req_addr", {imem_req_valid, imem_req_addr}, {1'b1, TAR_TGT + 32'd4});
        tick();
        redir_valid = 1'b1;
        redir_src   = 3'b010;
        #1;
        check("w010_pc_en", {pc_en, pc_src}, {1'b1, 3'b010});
        tick();
        redir_valid = 1'b0;
        drop_armed  = 1'b0;
        mem_lat     = 0;
        #1;
        check("w010_instr_valid", instr_valid, 1'b0);
        check("w010_new_req", {imem_req_valid, imem_req_addr}, {1'b1, BNE_TGT});

        // Memory never answers: error after TIMEOUT wait cycles, sticky until reset.
        tick();
        for (int i = 0; i < TIMEOUT; i++) begin
            check($sformatf("to_wait%0d_fetch_err", i), fetch_err, 1'b0);
            tick();
        end
        check("to_fetch_err", fetch_err, 1'b1);
        check("to_req_valid", imem_req_valid, 1'b0);
        redir_valid = 1'b1;
        redir_src   = 3'b011;
        #1;
        check("err_redir_pc_en", pc_en, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("err_sticky", {fetch_err, instr_valid, imem_req_valid, pc_en}, 4'b1000);
        end
        redir_valid = 1'b0;

        rst = 1'b0;
        #1;
        check("err_rst_fetch_err", fetch_err, 1'b0);
        mem_lat = 1;
        @(negedge clk);
        rst = 1'b1;
        wait_req(PC_RESET, "restart");
        wait_valid(PC_RESET, "restart");

        tick();
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #20000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
